// File: rtl/apb_protocol_checker.sv
// Passive APB4 protocol checker: tracks the bus phase, flags violations
// as sticky bits plus a pulse, and keeps transfer/error/wait statistics.
module apb_protocol_checker #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16,
    parameter int WAIT_W  = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NUM_SLV-1:0] PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [ADDR_W-1:0]  PADDR,
    input  logic [DATA_W-1:0]  PWDATA,
    input  logic [STRB_W-1:0]  PSTRB,
    input  logic               PREADY,
    input  logic               PSLVERR,
    input  logic               clr_stats,
    output logic [6:0]         err_vec,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   xfer_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   slverr_cnt,
    output logic [WAIT_W-1:0]  wait_max,
    output logic [2:0]         phase
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam longint WMAX = (64'd1 << WAIT_W) - 64'd1;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SLV-1:0] psel_lat_q, psel_lat_d;
    logic [ADDR_W-1:0]  paddr_lat_q, paddr_lat_d;
    logic               pwrite_lat_q, pwrite_lat_d;
    logic [DATA_W-1:0]  pwdata_lat_q, pwdata_lat_d;
    logic [STRB_W-1:0]  pstrb_lat_q, pstrb_lat_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

    logic [6:0]        err_vec_q, err_vec_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  slverr_cnt_q, slverr_cnt_d;
    logic [WAIT_W-1:0] wait_max_q, wait_max_d;

    logic s_idle, s_setup, s_access, s_wait, s_done;
    logic chk, diff, any_viol;
    logic [6:0] viol;
    logic [WAIT_W-1:0] wsat;

    assign s_idle   = (PSEL == '0);
    assign s_setup  = !s_idle && !PENABLE;
    assign s_access = !s_idle && PENABLE;
    assign s_wait   = s_access && !PREADY;
    assign s_done   = s_access && PREADY;
    assign chk      = (state_q != S_SYNC);

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: follow the bus; SYNC only leaves on IDLE or SETUP
    always_comb begin
        state_d = state_q;
        if (s_idle) begin
            state_d = S_IDLE;
        end else if (s_setup) begin
            state_d = S_SETUP;
        end else if (chk) begin
            state_d = s_wait ? S_WAIT : S_DONE;
        end
    end

    always_comb begin
        diff = (PSEL != psel_lat_q) || (PADDR != paddr_lat_q) ||
               (PWRITE != pwrite_lat_q) || (PSTRB != pstrb_lat_q) ||
               (pwrite_lat_q && (PWDATA != pwdata_lat_q));
        viol    = '0;
        viol[0] = ($countones(PSEL) > 1);
        viol[1] = s_access && ((state_q == S_IDLE) || (state_q == S_DONE));
        viol[2] = (state_q == S_SETUP) && !(s_access && (PSEL == psel_lat_q));
        viol[3] = s_access && ((state_q == S_SETUP) || (state_q == S_WAIT)) && diff;
        viol[4] = s_wait && (wcnt_q == WCNT_W'(TIMEOUT - 1));
        viol[5] = s_setup && !PWRITE && (PSTRB != '0);
        viol[6] = (state_q == S_WAIT) && !s_access;
        if (!chk) begin
            viol = '0;
        end
        any_viol = |viol;
    end

    // Output/datapath next values; clear is applied before new events
    always_comb begin
        psel_lat_d   = psel_lat_q;
        paddr_lat_d  = paddr_lat_q;
        pwrite_lat_d = pwrite_lat_q;
        pwdata_lat_d = pwdata_lat_q;
        pstrb_lat_d  = pstrb_lat_q;
        wcnt_d       = wcnt_q;
        if (s_setup) begin
            psel_lat_d   = PSEL;
            paddr_lat_d  = PADDR;
            pwrite_lat_d = PWRITE;
            pwdata_lat_d = PWDATA;
            pstrb_lat_d  = PSTRB;
            wcnt_d       = '0;
        end else if (chk && s_wait && (wcnt_q != WCNT_W'(TIMEOUT))) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        if (64'(wcnt_q) > WMAX) begin
            wsat = '1;
        end else begin
            wsat = WAIT_W'(wcnt_q);
        end

        err_vec_d    = clr_stats ? '0 : err_vec_q;
        xfer_cnt_d   = clr_stats ? '0 : xfer_cnt_q;
        err_cnt_d    = clr_stats ? '0 : err_cnt_q;
        slverr_cnt_d = clr_stats ? '0 : slverr_cnt_q;
        wait_max_d   = clr_stats ? '0 : wait_max_q;
        err_pulse_d  = any_viol;

        err_vec_d = err_vec_d | viol;
        if (any_viol && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end
        if (chk && s_done) begin
            if (xfer_cnt_d != '1) begin
                xfer_cnt_d = xfer_cnt_d + 1'b1;
            end
            if (PSLVERR && (slverr_cnt_d != '1)) begin
                slverr_cnt_d = slverr_cnt_d + 1'b1;
            end
            if (wsat > wait_max_d) begin
                wait_max_d = wsat;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            psel_lat_q   <= '0;
            paddr_lat_q  <= '0;
            pwrite_lat_q <= 1'b0;
            pwdata_lat_q <= '0;
            pstrb_lat_q  <= '0;
            wcnt_q       <= '0;
            err_vec_q    <= '0;
            err_pulse_q  <= 1'b0;
            xfer_cnt_q   <= '0;
            err_cnt_q    <= '0;
            slverr_cnt_q <= '0;
            wait_max_q   <= '0;
        end else begin
            psel_lat_q   <= psel_lat_d;
            paddr_lat_q  <= paddr_lat_d;
            pwrite_lat_q <= pwrite_lat_d;
            pwdata_lat_q <= pwdata_lat_d;
            pstrb_lat_q  <= pstrb_lat_d;
            wcnt_q       <= wcnt_d;
            err_vec_q    <= err_vec_d;
            err_pulse_q  <= err_pulse_d;
            xfer_cnt_q   <= xfer_cnt_d;
            err_cnt_q    <= err_cnt_d;
            slverr_cnt_q <= slverr_cnt_d;
            wait_max_q   <= wait_max_d;
        end
    end

    assign err_vec    = err_vec_q;
    assign err_pulse  = err_pulse_q;
    assign xfer_cnt   = xfer_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign slverr_cnt = slverr_cnt_q;
    assign wait_max   = wait_max_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker with an expectation queue
// popped and asserted one sample after each clock edge.
module tb_apb_protocol_checker;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int TO = 16;
    localparam int CW = 16;
    localparam int WW = 8;

    localparam int PH_SYNC  = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_SETUP = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_DONE  = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic          PREADY;
    logic          PSLVERR;
    logic          clr_stats;
    logic [6:0]    err_vec;
    logic          err_pulse;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] slverr_cnt;
    logic [WW-1:0] wait_max;
    logic [2:0]    phase;

    always #5 PCLK = ~PCLK;

    apb_protocol_checker #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NUM_SLV(NS),
        .TIMEOUT(TO),
        .CNT_W  (CW),
        .WAIT_W (WW)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .clr_stats (clr_stats),
        .err_vec   (err_vec),
        .err_pulse (err_pulse),
        .xfer_cnt  (xfer_cnt),
        .err_cnt   (err_cnt),
        .slverr_cnt(slverr_cnt),
        .wait_max  (wait_max),
        .phase     (phase)
    );

    typedef struct {
        string      tag;
        logic [6:0] ev;
        logic       ep;
        int         xc;
        int         ec;
        int         sc;
        int         wm;
        int         ph;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    task automatic exp_o(input string tag, input logic [6:0] ev, input logic ep,
                         input int xc, input int ec, input int sc,
                         input int wm, input int ph);
        exp_t e;
        e.tag = tag;
        e.ev  = ev;
        e.ep  = ep;
        e.xc  = xc;
        e.ec  = ec;
        e.sc  = sc;
        e.wm  = wm;
        e.ph  = ph;
        sb.push_back(e);
    endtask

    task automatic bus(input logic [NS-1:0] sel, input logic en, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] st, input logic rdy, input logic serr);
        PSEL    = sel;
        PENABLE = en;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        PSTRB   = st;
        PREADY  = rdy;
        PSLVERR = serr;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge PCLK);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, "err_vec", 32'(err_vec), 32'(e.ev));
            chk(e.tag, "err_pulse", 32'(err_pulse), 32'(e.ep));
            chk(e.tag, "xfer_cnt", 32'(xfer_cnt), e.xc);
            chk(e.tag, "err_cnt", 32'(err_cnt), e.ec);
            chk(e.tag, "slverr_cnt", 32'(slverr_cnt), e.sc);
            chk(e.tag, "wait_max", 32'(wait_max), e.wm);
            chk(e.tag, "phase", 32'(phase), e.ph);
        end
    endtask

    task automatic idle();
        bus('0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held while the bus sits in an ACCESS phase
        PRESET = 1'b1;
        clr_stats = 1'b0;
        bus(2'b01, 1'b1, 1'b1, 8'h10, '0, 4'hF, 1'b0, 1'b0);
        exp_o("rst1", 7'h00, 0, 0, 0, 0, 0, PH_SYNC); tick();
        exp_o("rst2", 7'h00, 0, 0, 0, 0, 0, PH_SYNC); tick();
        PRESET = 1'b0;
        exp_o("sync_wait", 7'h00, 0, 0, 0, 0, 0, PH_SYNC); tick();
        PREADY = 1'b1;
        exp_o("sync_done", 7'h00, 0, 0, 0, 0, 0, PH_SYNC); tick();
        idle();
        exp_o("sync_idle", 7'h00, 0, 0, 0, 0, 0, PH_IDLE); tick();

        // Clean write, two wait states
        bus(2'b01, 1'b0, 1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0);
        exp_o("wr_setup", 7'h00, 0, 0, 0, 0, 0, PH_SETUP); tick();
        PENABLE = 1'b1;
        exp_o("wr_w1", 7'h00, 0, 0, 0, 0, 0, PH_WAIT); tick();
        exp_o("wr_w2", 7'h00, 0, 0, 0, 0, 0, PH_WAIT); tick();
        PREADY = 1'b1;
        exp_o("wr_done", 7'h00, 0, 1, 0, 0, 2, PH_DONE); tick();
        idle();
        exp_o("wr_idle", 7'h00, 0, 1, 0, 0, 2, PH_IDLE); tick();

        // Address changes during the access phase
        bus(2'b01, 1'b0, 1'b1, 8'h10, 32'h12345678, 4'hF, 1'b0, 1'b0);
        exp_o("uns_setup", 7'h00, 0, 1, 0, 0, 2, PH_SETUP); tick();
        PENABLE = 1'b1;
        exp_o("uns_w1", 7'h00, 0, 1, 0, 0, 2, PH_WAIT); tick();
        PADDR = 8'h14;
        PREADY = 1'b1;
        exp_o("uns_bad", 7'h08, 1, 2, 1, 0, 2, PH_DONE); tick();
        idle();
        exp_o("uns_idle", 7'h08, 0, 2, 1, 0, 2, PH_IDLE); tick();

        // Read stalled for 30 cycles: timeout flagged once
        bus(2'b01, 1'b0, 1'b0, 8'h20, '0, 4'h0, 1'b0, 1'b0);
        exp_o("to_setup", 7'h08, 0, 2, 1, 0, 2, PH_SETUP); tick();
        PENABLE = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            exp_o($sformatf("to_w%0d", k), (k >= TO) ? 7'h18 : 7'h08,
                  (k == TO), 2, (k >= TO) ? 2 : 1, 0, 2, PH_WAIT);
            tick();
        end
        PREADY = 1'b1;
        exp_o("to_done", 7'h18, 0, 3, 2, 0, 16, PH_DONE); tick();
        idle();
        exp_o("to_idle", 7'h18, 0, 3, 2, 0, 16, PH_IDLE); tick();

        // Read with strobes while stats are cleared in the same cycle
        bus(2'b01, 1'b0, 1'b0, 8'h30, '0, 4'hF, 1'b0, 1'b0);
        clr_stats = 1'b1;
        exp_o("clr_rstrb", 7'h20, 1, 0, 1, 0, 0, PH_SETUP); tick();
        clr_stats = 1'b0;
        PENABLE = 1'b1;
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        exp_o("slverr_done", 7'h20, 0, 1, 1, 1, 0, PH_DONE); tick();

        // Back-to-back SETUP after DONE is legal
        bus(2'b01, 1'b0, 1'b1, 8'h50, 32'hCAFEF00D, 4'h3, 1'b0, 1'b0);
        exp_o("b2b_setup", 7'h20, 0, 1, 1, 1, 0, PH_SETUP); tick();
        PENABLE = 1'b1;
        PREADY = 1'b1;
        exp_o("b2b_done", 7'h20, 0, 2, 1, 1, 0, PH_DONE); tick();
        // ACCESS straight after DONE, then enable dropped mid-wait
        PREADY = 1'b0;
        exp_o("seq_after_done", 7'h22, 1, 2, 2, 1, 0, PH_WAIT); tick();
        idle();
        exp_o("enable_drop", 7'h62, 1, 2, 3, 1, 0, PH_IDLE); tick();

        clr_stats = 1'b1;
        exp_o("clr_idle", 7'h00, 0, 0, 0, 0, 0, PH_IDLE); tick();
        clr_stats = 1'b0;

        // Two selects at once, then ACCESS from IDLE
        bus(2'b11, 1'b0, 1'b1, 8'h40, '0, 4'hF, 1'b0, 1'b0);
        exp_o("multi_setup", 7'h01, 1, 0, 1, 0, 0, PH_SETUP); tick();
        PENABLE = 1'b1;
        PREADY = 1'b1;
        exp_o("multi_done", 7'h01, 1, 1, 2, 0, 0, PH_DONE); tick();
        idle();
        exp_o("multi_idle", 7'h01, 0, 1, 2, 0, 0, PH_IDLE); tick();
        bus(2'b01, 1'b1, 1'b1, 8'h44, '0, 4'hF, 1'b0, 1'b0);
        exp_o("seq_from_idle", 7'h03, 1, 1, 3, 0, 0, PH_WAIT); tick();
        idle();
        exp_o("seq_drop", 7'h43, 1, 1, 4, 0, 0, PH_IDLE); tick();

        // SETUP not followed by ACCESS
        bus(2'b01, 1'b0, 1'b1, 8'h60, '0, 4'hF, 1'b0, 1'b0);
        exp_o("noacc_setup", 7'h43, 0, 1, 4, 0, 0, PH_SETUP); tick();
        idle();
        exp_o("noacc_idle", 7'h47, 1, 1, 5, 0, 0, PH_IDLE); tick();

        // Reset wins over clear and over a violating sample
        PRESET = 1'b1;
        clr_stats = 1'b1;
        bus(2'b11, 1'b0, 1'b0, 8'h00, '0, 4'hF, 1'b0, 1'b0);
        exp_o("rst_prio", 7'h00, 0, 0, 0, 0, 0, PH_SYNC); tick();
        PRESET = 1'b0;
        clr_stats = 1'b0;
        idle();
        exp_o("rst_idle", 7'h00, 0, 0, 0, 0, 0, PH_IDLE); tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
